mem_port_arbiter: RTL and testbench

Sequences the single unified memory shared by instruction fetch and the data stage (load/store).
Arbitrates between the fetch request and the data request, and drives the memory address mux select, the write-data mux select, the read/write strobes and the PC write-enable.
It sits beside the fetch stage and replaces the hand-driven c1/c2/ler/escreve/PCescreve controls.
Data accesses take priority, with a bounded-streak guard so fetch is never starved.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter_streak_ctr.sv | 36 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Optional feature macro used by the arbiter files: STALL_COUNT_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } arb_state_e;

    localparam logic SEL_ADDR_PC   = 1'b0;
    localparam logic SEL_ADDR_ALU  = 1'b1;
    localparam logic SEL_WDATA_REG = 1'b0;
    localparam logic SEL_WDATA_FWD = 1'b1;

    function automatic logic is_data_state(input arb_state_e s);
        return (s == DREAD) || (s == DWRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/control bundle between the fetch/data requesters and the memory port arbiter.
// STALL_COUNT_EN adds the fetch_stall_cnt observation signal.
interface mem_port_arbiter_if;

    logic        if_req;
    logic        rd_req;
    logic        wr_req;
    logic        wdata_src;
    logic        sel_addr;
    logic        sel_wdata;
    logic        mem_read;
    logic        mem_write;
    logic        pc_write;
    logic        if_done;
    logic        mem_done;
    logic        busy;
    logic        proto_err;
`ifdef STALL_COUNT_EN
    logic [31:0] fetch_stall_cnt;
`endif

    modport master (
`ifdef STALL_COUNT_EN
        input  fetch_stall_cnt,
`endif
        output if_req, rd_req, wr_req, wdata_src,
        input  sel_addr, sel_wdata, mem_read, mem_write, pc_write,
        input  if_done, mem_done, busy, proto_err
    );

    modport slave (
`ifdef STALL_COUNT_EN
        output fetch_stall_cnt,
`endif
        input  if_req, rd_req, wr_req, wdata_src,
        output sel_addr, sel_wdata, mem_read, mem_write, pc_write,
        output if_done, mem_done, busy, proto_err
    );

endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Data-priority grant decision with a saturating streak counter that bounds
// how many data grants may pass a waiting fetch.
module arb_streak_ctr #(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_data_req,
    output logic o_grant_data,
    output logic o_grant_fetch
);

    localparam logic [3:0] MaxStreak = 4'(MAX_STREAK);

    logic [3:0] r_streak;
    logic       w_data_ok;

    always_comb begin
        w_data_ok     = (r_streak < MaxStreak) || !i_if_req;
        o_grant_data  = i_idle && i_data_req && w_data_ok;
        o_grant_fetch = i_idle && !o_grant_data && i_if_req;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_streak <= 4'd0;
        end else if (o_grant_data && i_if_req) begin
            if (r_streak != MaxStreak) r_streak <= r_streak + 4'd1;
        end else if (o_grant_data || o_grant_fetch) begin
            r_streak <= 4'd0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory and drives its mux selects and strobes.
// Define STALL_COUNT_EN to add the fetch_stall_cnt counter.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned MAX_STREAK = 4
) (
    input logic               clock,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] LatInit     = 4'(MEM_LAT - 1);
    localparam logic       LastOnGrant = (MEM_LAT == 1);

    arb_state_e r_state;
    logic [3:0] r_lat_cnt;
    logic       r_sel_addr;
    logic       r_sel_wdata;
    logic       r_mem_read;
    logic       r_mem_write;
    logic       r_pc_write;
    logic       r_if_done;
    logic       r_mem_done;
    logic       r_busy;
    logic       r_proto_err;

    logic       w_idle;
    logic       w_grant_data;
    logic       w_grant_fetch;
    logic       w_last;

    assign w_idle = (r_state == IDLE);
    assign w_last = (r_lat_cnt == 4'd1);

    arb_streak_ctr #(
        .MAX_STREAK (MAX_STREAK)
    ) u_streak (
        .clock         (clock),
        .reset         (reset),
        .i_idle        (w_idle),
        .i_if_req      (bus.if_req),
        .i_data_req    (bus.rd_req || bus.wr_req),
        .o_grant_data  (w_grant_data),
        .o_grant_fetch (w_grant_fetch)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lat_cnt   <= 4'd0;
            r_sel_addr  <= SEL_ADDR_PC;
            r_sel_wdata <= SEL_WDATA_REG;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_pc_write  <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
        end else if (w_idle) begin
            if (bus.rd_req && bus.wr_req) r_proto_err <= 1'b1;
            if (w_grant_data) begin
                r_state     <= bus.wr_req ? DWRITE : DREAD;
                r_lat_cnt   <= LatInit;
                r_sel_addr  <= SEL_ADDR_ALU;
                r_mem_read  <= !bus.wr_req;
                r_mem_write <= bus.wr_req;
                r_busy      <= 1'b1;
                r_mem_done  <= LastOnGrant;
                if (bus.wr_req) r_sel_wdata <= bus.wdata_src;
            end else if (w_grant_fetch) begin
                r_state     <= FETCH;
                r_lat_cnt   <= LatInit;
                r_sel_addr  <= SEL_ADDR_PC;
                r_mem_read  <= 1'b1;
                r_busy      <= 1'b1;
                r_if_done   <= LastOnGrant;
                r_pc_write  <= LastOnGrant;
            end
        end else if (r_lat_cnt == 4'd0) begin
            // Always fall back to IDLE so the requester can drop its request.
            r_state     <= IDLE;
            r_sel_addr  <= SEL_ADDR_PC;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_pc_write  <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
            if (is_data_state(r_state)) begin
                r_mem_done <= w_last;
            end else begin
                r_if_done  <= w_last;
                r_pc_write <= w_last;
            end
        end
    end

    assign bus.sel_addr  = r_sel_addr;
    assign bus.sel_wdata = r_sel_wdata;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.pc_write  = r_pc_write;
    assign bus.if_done   = r_if_done;
    assign bus.mem_done  = r_mem_done;
    assign bus.busy      = r_busy;
    assign bus.proto_err = r_proto_err;

`ifdef STALL_COUNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (bus.if_req && (r_state != FETCH)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.fetch_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiter instances (MEM_LAT=1 and MEM_LAT=3); expected
// access responses are queued at issue and popped by a monitor on each done pulse.
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // {if_done, mem_done, pc_write, sel_addr, mem_read, mem_write, busy, sel_wdata}
    logic [7:0] q1[$];
    logic [7:0] q3[$];

    always #5 clock = ~clock;

    mem_port_arbiter_if if1 ();
    mem_port_arbiter_if if3 ();

    mem_port_arbiter #(
        .MEM_LAT    (1),
        .MAX_STREAK (4)
    ) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    mem_port_arbiter #(
        .MEM_LAT    (3),
        .MAX_STREAK (4)
    ) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (if3)
    );

    function automatic logic [7:0] exp_fetch(input logic sw);
        return {7'b1010101, sw};
    endfunction

    function automatic logic [7:0] exp_read(input logic sw);
        return {7'b0101101, sw};
    endfunction

    function automatic logic [7:0] exp_write(input logic sw);
        return {7'b0101011, sw};
    endfunction

    function automatic logic [8:0] outs(input bit d3);
        if (d3)
            return {if3.if_done, if3.mem_done, if3.pc_write, if3.sel_addr, if3.mem_read,
                    if3.mem_write, if3.busy, if3.sel_wdata, if3.proto_err};
        return {if1.if_done, if1.mem_done, if1.pc_write, if1.sel_addr, if1.mem_read,
                if1.mem_write, if1.busy, if1.sel_wdata, if1.proto_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spurious(input string name, input logic [8:0] v);
        total++;
        bad++;
        $display("FAIL %s: got done with outputs %b expected no done", name, v);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (if1.if_done || if1.mem_done) begin
                if (q1.size() == 0) spurious("dut1 unexpected done", outs(0));
                else check("dut1 access", 32'(outs(0) >> 1), 32'(q1.pop_front()));
            end
            if (if3.if_done || if3.mem_done) begin
                if (q3.size() == 0) spurious("dut3 unexpected done", outs(1));
                else check("dut3 access", 32'(outs(1) >> 1), 32'(q3.pop_front()));
            end
        end
    endtask

    task automatic wait_done(input bit d3, input bit fetch, input int exp_cyc, input string name);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clock);
            n++;
            if (d3) seen = fetch ? if3.if_done : if3.mem_done;
            else    seen = fetch ? if1.if_done : if1.mem_done;
        end
        check(name, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        int nd;
        int nf;
        int cyc;
        fork
            monitor();
        join_none
        {if1.if_req, if1.rd_req, if1.wr_req, if1.wdata_src} = 4'b0;
        {if3.if_req, if3.rd_req, if3.wr_req, if3.wdata_src} = 4'b0;
        #1;
        check("reset dut1 outputs", 32'(outs(0)), 32'd0);
        check("reset dut3 outputs", 32'(outs(1)), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle dut1 outputs", 32'(outs(0)), 32'd0);
`ifdef STALL_COUNT_EN
        check("stall cnt reset", if3.fetch_stall_cnt, 32'd0);
`endif

        // Single fetch, MEM_LAT=1.
        q1.push_back(exp_fetch(1'b0));
        if1.if_req = 1'b1;
        wait_done(0, 1, 1, "t1 fetch latency");
        if1.if_req = 1'b0;
        @(negedge clock);
        check("t1 back to idle", 32'(outs(0)), 32'd0);

        // Data wins over a simultaneous fetch; fetch after one turnaround.
        q1.push_back(exp_read(1'b0));
        q1.push_back(exp_fetch(1'b0));
        if1.if_req = 1'b1;
        if1.rd_req = 1'b1;
        wait_done(0, 0, 1, "t2 read first");
        if1.rd_req = 1'b0;
        wait_done(0, 1, 2, "t2 fetch after turnaround");
        if1.if_req = 1'b0;
        @(negedge clock);

        // Streak guard: 4 reads, 1 fetch, then data resumes.
        repeat (4) q1.push_back(exp_read(1'b0));
        q1.push_back(exp_fetch(1'b0));
        q1.push_back(exp_read(1'b0));
        if1.if_req = 1'b1;
        if1.rd_req = 1'b1;
        nd  = 0;
        nf  = 0;
        cyc = 0;
        while (nd < 5 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (if1.if_done) begin
                nf++;
                if1.if_req = 1'b0;
            end
            if (if1.mem_done) begin
                nd++;
                if (nd == 5) if1.rd_req = 1'b0;
            end
        end
        check("t3 data grants", 32'(nd), 32'd5);
        check("t3 fetch grants", 32'(nf), 32'd1);
        check("t3 cycles", 32'(cyc), 32'd11);
        @(negedge clock);

        // Read and write together: write wins, sticky protocol error.
        q1.push_back(exp_write(1'b1));
        if1.wdata_src = 1'b1;
        if1.rd_req    = 1'b1;
        if1.wr_req    = 1'b1;
        wait_done(0, 0, 1, "t4 write latency");
        check("t4 proto_err set", 32'(if1.proto_err), 32'd1);
        {if1.rd_req, if1.wr_req, if1.wdata_src} = 3'b0;
        repeat (3) @(negedge clock);
        check("t4 proto_err sticky", 32'(if1.proto_err), 32'd1);
        check("t4 sel_wdata holds", 32'(if1.sel_wdata), 32'd1);
        check("t4 idle strobes", 32'({if1.mem_write, if1.mem_read, if1.busy}), 32'd0);

        // MEM_LAT=3 write, wdata_src toggled mid-access.
        q3.push_back(exp_write(1'b1));
        if3.wdata_src = 1'b1;
        if3.wr_req    = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            check($sformatf("t5 write cycle %0d", i),
                  32'({if3.mem_write, if3.sel_wdata, if3.mem_done, if3.busy}),
                  32'({1'b1, 1'b1, (i == 3), 1'b1}));
            if (i == 1) if3.wdata_src = 1'b0;
        end
        if3.wr_req = 1'b0;
        @(negedge clock);
        check("t5 idle after write", 32'({if3.busy, if3.mem_write, if3.sel_wdata}), 32'd1);

        // MEM_LAT=3 read beside a pending fetch.
        q3.push_back(exp_read(1'b1));
        q3.push_back(exp_fetch(1'b1));
        if3.if_req = 1'b1;
        if3.rd_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            check($sformatf("t6 read cycle %0d", i),
                  32'({if3.mem_read, if3.sel_addr, if3.mem_done}), 32'({2'b11, (i == 3)}));
        end
`ifdef STALL_COUNT_EN
        check("t6 stall cnt after read", if3.fetch_stall_cnt, 32'd3);
`endif
        if3.rd_req = 1'b0;
        wait_done(1, 1, 4, "t6 fetch latency");
`ifdef STALL_COUNT_EN
        check("t6 stall cnt after fetch", if3.fetch_stall_cnt, 32'd5);
`endif
        if3.if_req = 1'b0;
        @(negedge clock);

        // Reset in the second cycle of a MEM_LAT=3 read aborts it.
        if3.rd_req = 1'b1;
        @(negedge clock);
        check("t7 read cycle 1", 32'({if3.mem_read, if3.busy, if3.mem_done}), 32'b110);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("t7 dut3 cleared by reset", 32'(outs(1)), 32'd0);
        check("t7 dut1 proto_err cleared", 32'(if1.proto_err), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        q3.push_back(exp_read(1'b0));
        wait_done(1, 0, 3, "t7 regrant latency");
        if3.rd_req = 1'b0;

        repeat (4) @(negedge clock);
        check("scoreboard drained", 32'(q1.size() + q3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
